prog_loader_mem: RTL and testbench

- Parametrised program memory for the picoMIPS core, with a registered read port.
- Adds a chunked boot-load port so the program can be rewritten at run time without re-synthesis.
- A three-state load controller stalls the core during a load and feeds it NOP until the fetch data is valid again.
- Sits between the PC and the instruction decoder.

---
 rtl/prog_loader_mem.sv | 141 ++++++++++++++
 tb/tb_prog_loader_mem.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_mem.sv
// Program memory for the picoMIPS core with a registered fetch port and a
// chunked boot-load port. A RUN/LOAD/DRAIN controller holds the core in
// stall while a new program streams in, then spends one DRAIN cycle
// refetching so valid instruction data and stall=0 appear together.
// Program contents arrive through the boot-load port; the array is not
// touched by reset, so a loaded program survives a core reset.
//
// Load handshake: a chunk transfers on a rising edge where ld_valid and
// ld_ready are both high; ld_ready is high only in LOAD, and ld_data/ld_last
// must be stable with ld_valid. The loader waits indefinitely for ld_valid.
module prog_loader_mem #(
  parameter int               Psize = 4,
  parameter int               Isize = 17,
  parameter int               Lsize = 8,
  parameter logic [Isize-1:0] NOP   = '0
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [Psize-1:0] address,
  output logic [Isize-1:0] I,
  output logic             stall,
  input  logic             load_start,
  input  logic [Lsize-1:0] ld_data,
  input  logic             ld_valid,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic [Psize:0]   words_loaded,
  output logic             load_err,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = (Isize + Lsize - 1) / Lsize;
  localparam int AW     = NCHUNK * Lsize;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int DEPTH  = 1 << Psize;

  localparam logic [CW-1:0]    LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [Psize-1:0] LAST_ADDR  = '1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [Isize-1:0] mem [DEPTH];
  logic [Psize-1:0] wr_addr;
  logic [CW-1:0]    chunk_cnt;
  logic [AW-1:0]    asm_q;
  logic [AW-1:0]    asm_next;
  logic             xfer;
  logic             last_chunk;
  logic             wr_en;

  assign dbg_state  = state;
  // ld_ready is high exactly in LOAD, so it doubles as the state qualifier.
  assign xfer       = ld_ready && ld_valid;
  assign last_chunk = (chunk_cnt == LAST_CHUNK);
  assign wr_en      = xfer && last_chunk;

  // Merge the incoming chunk into the assembly word so the final chunk is
  // written to memory in the same cycle it arrives.
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(chunk_cnt) * Lsize +: Lsize] = ld_data;
  end

  // Memory write port; bits of the final chunk above Isize are dropped here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= asm_next[Isize-1:0];
    end
  end

  // Load controller with registered fetch, stall and ready outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= S_RUN;
      I            <= NOP;
      stall        <= 1'b0;
      ld_ready     <= 1'b0;
      words_loaded <= '0;
      load_err     <= 1'b0;
      wr_addr      <= '0;
      chunk_cnt    <= '0;
      asm_q        <= '0;
    end else begin
      case (state)
        S_RUN: begin
          I <= mem[address];
          if (load_start) begin
            state        <= S_LOAD;
            stall        <= 1'b1;
            ld_ready     <= 1'b1;
            wr_addr      <= '0;
            chunk_cnt    <= '0;
            words_loaded <= '0;
            load_err     <= 1'b0;
          end
        end
        S_LOAD: begin
          I <= NOP;
          if (xfer) begin
            asm_q <= asm_next;
            if (last_chunk) begin
              wr_addr      <= wr_addr + 1'b1;
              words_loaded <= words_loaded + 1'b1;
              chunk_cnt    <= '0;
              // End on the marked last word or when the array is full.
              if (ld_last || (wr_addr == LAST_ADDR)) begin
                state    <= S_DRAIN;
                ld_ready <= 1'b0;
              end
            end else if (ld_last) begin
              // Partial word: discard it and flag the error.
              chunk_cnt <= '0;
              load_err  <= 1'b1;
              state     <= S_DRAIN;
              ld_ready  <= 1'b0;
            end else begin
              chunk_cnt <= chunk_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          I     <= mem[address];
          stall <= 1'b0;
          state <= S_RUN;
        end
        default: begin
          state    <= S_RUN;
          I        <= NOP;
          stall    <= 1'b0;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader_mem.sv
// Bench for prog_loader_mem: random program images are streamed through the
// boot-load port, a word-level model tracks what memory must hold, and every
// fetch pushes its expected instruction for a negedge monitor to compare.
module tb_prog_loader_mem;

  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        n_reset;
  logic [3:0]  address;
  logic [16:0] I;
  logic        stall;
  logic        load_start;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_last;
  logic        ld_ready;
  logic [4:0]  words_loaded;
  logic        load_err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  prog_loader_mem #(.Psize(4), .Isize(17), .Lsize(8), .NOP(17'h0)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .address      (address),
    .I            (I),
    .stall        (stall),
    .load_start   (load_start),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .words_loaded (words_loaded),
    .load_err     (load_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [16:0] ref_mem [DEPTH];
  logic [16:0] wval [DEPTH];
  logic [6:0]  junk [DEPTH];
  int          exp_words;
  logic        exp_err;

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one registered fetch result per pushed expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      check("fetch_I", {15'd0, I}, {15'd0, e});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic new_words();
    for (int i = 0; i < DEPTH; i++) begin
      wval[i] = 17'($urandom);
      junk[i] = 7'($urandom);
    end
  endtask

  task automatic fetch(input int a);
    address = 4'(a);
    @(posedge clk);
    exp_q.push_back(ref_mem[a]);
    #1;
    check("fetch_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic fetch_all();
    for (int a = 0; a < DEPTH; a++) fetch(a);
    for (int k = 0; k < 8; k++) fetch($urandom_range(0, DEPTH - 1));
  endtask

  task automatic start_load();
    exp_words  = 0;
    exp_err    = 1'b0;
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    check("load_stall", {31'd0, stall}, 32'd1);
    check("load_ready", {31'd0, ld_ready}, 32'd1);
    check("load_words_clr", {27'd0, words_loaded}, 32'd0);
  endtask

  // Send one chunk and wait (bounded) for it to be accepted.
  task automatic send_chunk(input logic [7:0] d, input logic last, output logic ok);
    logic rdy;
    ok       = 1'b0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      rdy = ld_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 8'($urandom);
    if (!ok) check("chunk_timeout", 32'd0, 32'd1);
  endtask

  // Stream chunk indices 0..total-1 (3 chunks per word, LSB first);
  // ld_last rides on chunk index last_at. The model writes a word once all
  // three of its chunks have been sent.
  task automatic stream(input int total, input int last_at, input bit gaps);
    logic [23:0] w24;
    logic        ok;
    for (int n = 0; n < total; n++) begin
      int w;
      int c;
      w = n / 3;
      c = n % 3;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          ld_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      w24 = {junk[w], wval[w]};
      send_chunk(w24[c*8 +: 8], (n == last_at), ok);
      if (!ok) return;
      if (c == 2) begin
        ref_mem[w] = wval[w];
        exp_words++;
      end else if (n == last_at) begin
        exp_err = 1'b1;
      end
      if (n == last_at) return;
    end
  endtask

  // Called right after the final transfer edge: expect one DRAIN cycle.
  task automatic finish_load();
    check("drain_ready", {31'd0, ld_ready}, 32'd0);
    check("drain_stall", {31'd0, stall}, 32'd1);
    check("drain_I_nop", {15'd0, I}, 32'd0);
    @(posedge clk);
    #1;
    check("run_stall", {31'd0, stall}, 32'd0);
    check("words_loaded", {27'd0, words_loaded}, 32'(exp_words));
    check("load_err", {31'd0, load_err}, {31'd0, exp_err});
  endtask

  task automatic check_reset_outputs();
    check("rst_I", {15'd0, I}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_words", {27'd0, words_loaded}, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2;
    n_reset = 1'b0;
    #1;
    check_reset_outputs();
    n_reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    n_reset    = 1'b0;
    address    = '0;
    load_start = 1'b0;
    ld_data    = '0;
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    // Preload mem[i] = i through the load port (full image, ld_last on word 15).
    for (int i = 0; i < DEPTH; i++) begin
      wval[i] = 17'(i);
      junk[i] = '0;
    end
    start_load();
    stream(48, 47, 1'b0);
    finish_load();

    // Read latency after a reset: NOP first, then i one clock after address i.
    pulse_reset();
    for (int a = 0; a < DEPTH; a++) fetch(a);

    // Full load of three words, word 0 = chunks 34,12,01.
    new_words();
    wval[0] = 17'h11234;
    junk[0] = '0;
    start_load();
    stream(9, 8, 1'b0);
    finish_load();
    fetch(0);
    fetch_all();

    // Gaps in ld_valid between chunks.
    new_words();
    start_load();
    stream(6, 5, 1'b1);
    finish_load();
    fetch_all();

    // Early ld_last on chunk 1 of word 2.
    new_words();
    start_load();
    stream(8, 7, 1'b0);
    finish_load();
    fetch_all();

    // Overflow: 48 chunks with no ld_last, then further valid chunks ignored.
    new_words();
    start_load();
    stream(48, -1, 1'b1);
    finish_load();
    ld_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ld_data = 8'($urandom);
      @(posedge clk);
      #1;
      check("ovf_ready", {31'd0, ld_ready}, 32'd0);
      check("ovf_words", {27'd0, words_loaded}, 32'd16);
    end
    ld_valid = 1'b0;
    fetch_all();

    // Reset after word 1 chunk 1: word 0 kept, word 1 keeps old contents.
    new_words();
    start_load();
    stream(5, -1, 1'b0);
    pulse_reset();
    fetch_all();

    // Random loads of random length, ld_last on the final chunk sent.
    for (int r = 0; r < 4; r++) begin
      int total;
      new_words();
      total = $urandom_range(1, 48);
      start_load();
      stream(total, total - 1, ($urandom_range(0, 1) == 1));
      finish_load();
      fetch_all();
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
